// File: rtl/udma_i2c_cmd_seq.sv
// rtl/udma_i2c_cmd_seq.sv - uDMA I2C command sequencer driving a bit-level bus controller
// Purpose: pops 32-bit commands ([31:28] opcode, [27:0] arg) and turns them into
//   START/STOP/RDBIT/WRBIT/WAIT requests for an external bit-level controller,
//   moving bytes between the uDMA tx/rx streams and the bus.
// Optional feature macro: I2C_CMD_SEQ_TIMEOUT_EN (bus-done watchdog, parameter TIMEOUT_CYC).
// Ports:
//   clk_i, rstn_i (sync, active-low), sw_rst_i (soft reset, drains tx/rx while high)
//   ext_events_i                          event pulses for WAIT_EV
//   udma_cmd_i/_valid_i/_ready_o          command channel
//   data_tx_i/_valid_i/_ready_o           tx bytes to be written on the bus
//   data_rx_o/_valid_o/_ready_i           rx bytes read from the bus
//   bus_cmd_o/_valid_o, bus_din_o         request to controller (one-cycle pulse)
//   bus_cmd_done_i, bus_dout_i, bus_al_i  controller status
//   clk_div_o                             divider for controller
//   eot_o, nack_o, err_o                  status pulses
module udma_i2c_cmd_seq #(
  parameter int NUM_EVENTS = 4,
  parameter int DIV_W      = 16,
  parameter int RPT_W      = 16
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 65536
`endif
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  sw_rst_i,
  input  logic [NUM_EVENTS-1:0] ext_events_i,
  input  logic [31:0]           udma_cmd_i,
  input  logic                  udma_cmd_valid_i,
  output logic                  udma_cmd_ready_o,
  input  logic [7:0]            data_tx_i,
  input  logic                  data_tx_valid_i,
  output logic                  data_tx_ready_o,
  output logic [7:0]            data_rx_o,
  output logic                  data_rx_valid_o,
  input  logic                  data_rx_ready_i,
  output logic [2:0]            bus_cmd_o,
  output logic                  bus_cmd_valid_o,
  input  logic                  bus_cmd_done_i,
  output logic                  bus_din_o,
  input  logic                  bus_dout_i,
  input  logic                  bus_al_i,
  output logic [DIV_W-1:0]      clk_div_o,
  output logic                  eot_o,
  output logic                  nack_o,
  output logic                  err_o
);

  localparam int EV_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

  localparam logic [3:0] OP_START = 4'h0, OP_STOP = 4'h2, OP_RD_ACK = 4'h4, OP_RD_NACK = 4'h6,
                         OP_WR = 4'h8, OP_WAIT = 4'hA, OP_RPT = 4'hC, OP_CFG = 4'hE,
                         OP_WAIT_EV = 4'h1, OP_WRB = 4'h7, OP_EOT = 4'h9;

  localparam logic [2:0] BUS_NONE = 3'd0, BUS_START = 3'd1, BUS_STOP = 3'd2,
                         BUS_RDBIT = 3'd3, BUS_WRBIT = 3'd4, BUS_WAIT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_DONE, S_WAIT_EV, S_READ, S_STORE, S_GET_DATA, S_WRITE, S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        bits_q, bits_d;
  logic [RPT_W-1:0]  rpt_q, rpt_d;
  logic [7:0]        data_q, data_d;
  logic              mack_q, mack_d;
  logic              ack_chk_q, ack_chk_d;
  logic [EV_W-1:0]   ev_sel_q, ev_sel_d;
  logic [DIV_W-1:0]  clk_div_q, clk_div_d;
  logic              al_q;

  logic [3:0]            opcode;
  logic [RPT_W-1:0]      rpt_arg;
  logic [(1<<EV_W)-1:0]  ev_pad;
  logic                  ev_hit;
  logic                  unused_cmd_bits;

  assign opcode          = udma_cmd_i[31:28];
  assign rpt_arg         = udma_cmd_i[RPT_W-1:0];
  assign data_rx_o       = data_q;
  assign clk_div_o       = clk_div_q;
  assign unused_cmd_bits = ^udma_cmd_i;

  // Selects beyond NUM_EVENTS read a zero-padded slot, so they never fire.
  always_comb begin
    ev_pad                 = '0;
    ev_pad[NUM_EVENTS-1:0] = ext_events_i;
    ev_hit                 = ev_pad[ev_sel_q];
  end

`ifdef I2C_CMD_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_wait;
  logic             tmo_fire;
  assign tmo_wait = (state_q == S_CMD_DONE) || (state_q == S_READ) || (state_q == S_WRITE);
`endif

  always_comb begin
    state_d = state_q;  bits_d = bits_q;  rpt_d = rpt_q;  data_d = data_q;
    mack_d = mack_q;  ack_chk_d = ack_chk_q;  ev_sel_d = ev_sel_q;  clk_div_d = clk_div_q;
    udma_cmd_ready_o = 1'b0;  data_tx_ready_o = 1'b0;  data_rx_valid_o = 1'b0;
    bus_cmd_o = BUS_NONE;  bus_cmd_valid_o = 1'b0;  bus_din_o = 1'b0;
    eot_o = 1'b0;  nack_o = 1'b0;
    err_o = bus_al_i & ~al_q;

    case (state_q)
      S_IDLE: begin
        udma_cmd_ready_o = 1'b1;
        if (udma_cmd_valid_i) begin
          case (opcode)
            OP_START, OP_STOP: begin
              bus_cmd_valid_o = 1'b1;
              bus_cmd_o = (opcode == OP_START) ? BUS_START : BUS_STOP;
              bits_d = 8'd0;  state_d = S_CMD_DONE;
            end
            OP_WAIT: begin
              bus_cmd_valid_o = 1'b1;  bus_cmd_o = BUS_WAIT;
              bits_d = udma_cmd_i[7:0];  state_d = S_CMD_DONE;
            end
            OP_EOT: eot_o = 1'b1;
            OP_WAIT_EV: begin
              ev_sel_d = udma_cmd_i[24 +: EV_W];
              bits_d = udma_cmd_i[7:0];  state_d = S_WAIT_EV;
            end
            OP_RD_ACK, OP_RD_NACK: begin
              bus_cmd_valid_o = 1'b1;  bus_cmd_o = BUS_RDBIT;
              mack_d = (opcode == OP_RD_NACK);
              bits_d = 8'd8;  state_d = S_READ;
            end
            OP_WR: state_d = S_GET_DATA;
            OP_WRB: begin
              bus_cmd_valid_o = 1'b1;  bus_cmd_o = BUS_WRBIT;  bus_din_o = udma_cmd_i[7];
              data_d = udma_cmd_i[7:0];  bits_d = 8'd8;  state_d = S_WRITE;
            end
            OP_RPT: begin
              // rpt holds extra iterations; a zero count instead swallows one tx byte.
              if (rpt_arg == '0) begin
                rpt_d = '0;  state_d = S_DRAIN;
              end else begin
                rpt_d = rpt_arg - RPT_W'(1);
              end
            end
            OP_CFG: begin
              clk_div_d = udma_cmd_i[DIV_W-1:0];
              ack_chk_d = udma_cmd_i[27];
            end
            default: ;
          endcase
        end
      end
      S_CMD_DONE: begin
        if (bus_cmd_done_i) begin
          if (bits_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            bus_cmd_valid_o = 1'b1;  bus_cmd_o = BUS_WAIT;  bits_d = bits_q - 8'd1;
          end
        end
      end
      S_WAIT_EV: begin
        if (ev_hit) begin
          if (bits_q == 8'd0) state_d = S_IDLE;
          else                bits_d  = bits_q - 8'd1;
        end
      end
      S_READ: begin
        // bits counts data bits still in flight; 0 means the master ACK slot just finished.
        if (bus_cmd_done_i) begin
          if (bits_q != 8'd0) data_d = {data_q[6:0], bus_dout_i};
          if (bits_q > 8'd1) begin
            bus_cmd_valid_o = 1'b1;  bus_cmd_o = BUS_RDBIT;  bits_d = bits_q - 8'd1;
          end else if (bits_q == 8'd1) begin
            bus_cmd_valid_o = 1'b1;  bus_cmd_o = BUS_WRBIT;  bus_din_o = mack_q;  bits_d = 8'd0;
          end else begin
            state_d = S_STORE;
          end
        end
      end
      S_STORE: begin
        data_rx_valid_o = 1'b1;
        if (data_rx_ready_i) begin
          if (rpt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            rpt_d = rpt_q - RPT_W'(1);
            bus_cmd_valid_o = 1'b1;  bus_cmd_o = BUS_RDBIT;
            bits_d = 8'd8;  state_d = S_READ;
          end
        end
      end
      S_GET_DATA: begin
        data_tx_ready_o = 1'b1;
        if (data_tx_valid_i) begin
          data_d = data_tx_i;
          bus_cmd_valid_o = 1'b1;  bus_cmd_o = BUS_WRBIT;  bus_din_o = data_tx_i[7];
          bits_d = 8'd8;  state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus_cmd_done_i) begin
          if (bits_q > 8'd1) begin
            data_d = {data_q[6:0], 1'b0};
            bus_cmd_valid_o = 1'b1;  bus_cmd_o = BUS_WRBIT;  bus_din_o = data_q[6];
            bits_d = bits_q - 8'd1;
          end else if (bits_q == 8'd1) begin
            bus_cmd_valid_o = 1'b1;  bus_cmd_o = BUS_RDBIT;  bits_d = 8'd0;
          end else begin
            nack_o = bus_dout_i;
            if (ack_chk_q && bus_dout_i) begin
              rpt_d = '0;  state_d = S_IDLE;
            end else if (rpt_q != '0) begin
              rpt_d = rpt_q - RPT_W'(1);  state_d = S_GET_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_DRAIN: begin
        data_tx_ready_o = 1'b1;
        if (data_tx_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef I2C_CMD_SEQ_TIMEOUT_EN
    // Watchdog: a controller that never answers is closed out with a STOP.
    tmo_fire = 1'b0;
    if (tmo_wait && !bus_cmd_done_i && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1))) begin
      tmo_fire = 1'b1;
      bus_cmd_valid_o = 1'b1;  bus_cmd_o = BUS_STOP;  bus_din_o = 1'b0;
      rpt_d = '0;  bits_d = 8'd0;  state_d = S_CMD_DONE;
    end
    err_o = err_o | tmo_fire;
`endif

    // Soft reset drains both streams so upstream/downstream never stall on us.
    if (sw_rst_i) begin
      data_tx_ready_o = 1'b1;
      data_rx_valid_o = 1'b1;
    end
    if (!rstn_i || sw_rst_i) begin
      udma_cmd_ready_o = 1'b0;  bus_cmd_valid_o = 1'b0;  bus_cmd_o = BUS_NONE;
      eot_o = 1'b0;  nack_o = 1'b0;  err_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || sw_rst_i) begin
      state_q   <= S_IDLE;
      bits_q    <= '0;
      rpt_q     <= '0;
      data_q    <= '0;
      mack_q    <= 1'b0;
      ack_chk_q <= 1'b0;
      ev_sel_q  <= '0;
      clk_div_q <= DIV_W'('h100);
      al_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bits_q    <= bits_d;
      rpt_q     <= rpt_d;
      data_q    <= data_d;
      mack_q    <= mack_d;
      ack_chk_q <= ack_chk_d;
      ev_sel_q  <= ev_sel_d;
      clk_div_q <= clk_div_d;
      al_q      <= bus_al_i;
    end
  end

`ifdef I2C_CMD_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i || sw_rst_i || bus_cmd_valid_o || !tmo_wait) tmo_cnt_q <= '0;
    else if (!bus_cmd_done_i)                                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end
`endif

endmodule

// File: tb/tb_udma_i2c_cmd_seq.sv
// tb/tb_udma_i2c_cmd_seq.sv - scoreboard testbench for udma_i2c_cmd_seq
module tb_udma_i2c_cmd_seq;
  localparam logic [2:0] B_START = 3'd1, B_STOP = 3'd2, B_RD = 3'd3, B_WR = 3'd4, B_WAIT = 3'd5;

  logic        clk = 1'b0;
  logic        rstn_i, sw_rst_i;
  logic [3:0]  ext_events_i;
  logic [31:0] udma_cmd_i;
  logic        udma_cmd_valid_i, udma_cmd_ready_o;
  logic [7:0]  data_tx_i;
  logic        data_tx_valid_i, data_tx_ready_o;
  logic [7:0]  data_rx_o;
  logic        data_rx_valid_o, data_rx_ready_i;
  logic [2:0]  bus_cmd_o;
  logic        bus_cmd_valid_o, bus_cmd_done_i, bus_din_o, bus_dout_i, bus_al_i;
  logic [15:0] clk_div_o;
  logic        eot_o, nack_o, err_o;

  always #5 clk = ~clk;

  udma_i2c_cmd_seq dut (
    .clk_i(clk), .rstn_i(rstn_i), .sw_rst_i(sw_rst_i), .ext_events_i(ext_events_i),
    .udma_cmd_i(udma_cmd_i), .udma_cmd_valid_i(udma_cmd_valid_i), .udma_cmd_ready_o(udma_cmd_ready_o),
    .data_tx_i(data_tx_i), .data_tx_valid_i(data_tx_valid_i), .data_tx_ready_o(data_tx_ready_o),
    .data_rx_o(data_rx_o), .data_rx_valid_o(data_rx_valid_o), .data_rx_ready_i(data_rx_ready_i),
    .bus_cmd_o(bus_cmd_o), .bus_cmd_valid_o(bus_cmd_valid_o), .bus_cmd_done_i(bus_cmd_done_i),
    .bus_din_o(bus_din_o), .bus_dout_i(bus_dout_i), .bus_al_i(bus_al_i),
    .clk_div_o(clk_div_o), .eot_o(eot_o), .nack_o(nack_o), .err_o(err_o)
  );

  int checks = 0, errors = 0;
  logic [3:0] exp_bus[$];
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  bit         rd_q[$];
  int nack_cnt = 0, eot_cnt = 0, tx_cnt = 0, err_cnt = 0;
  bit tx_taken = 0, pend = 0, outst = 0;
  int lat_cnt = 0;
  logic [2:0] pend_cmd = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic exp_write(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bus.push_back({B_WR, b[i]});
    exp_bus.push_back({B_RD, 1'b0});
  endtask

  task automatic exp_read(input logic [7:0] b, input bit mack);
    for (int i = 7; i >= 0; i--) begin
      exp_bus.push_back({B_RD, 1'b0});
      rd_q.push_back(b[i]);
    end
    exp_bus.push_back({B_WR, mack});
    exp_rx.push_back(b);
  endtask

  task automatic send_cmd(input logic [31:0] c);
    int n = 0;
    udma_cmd_i = c;
    udma_cmd_valid_i = 1'b1;
    do begin @(negedge clk); n++; end while (!udma_cmd_ready_o && n < 2000);
    if (!udma_cmd_ready_o) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: cmd 0x%0h not accepted", c);
    end
    sync();
    udma_cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!udma_cmd_ready_o && n < 2000);
    check({name, "_idle"}, udma_cmd_ready_o, 1);
    sync();
  endtask

  task automatic pulse_ev(input int k);
    ext_events_i = 4'(1 << k);
    sync();
    ext_events_i = 4'd0;
    @(negedge clk);
  endtask

  // Monitor: compares every bus request / rx handshake against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_cmd_done_i) outst = 0;
      if (bus_cmd_valid_o) begin
        check("bus_overlap", outst, 0);
        outst = 1;
        pend = 1; pend_cmd = bus_cmd_o; lat_cnt = 3;
        if (exp_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_extra: got cmd %0d din %0d with nothing expected", bus_cmd_o, bus_din_o);
        end else begin
          check("bus_cmd", {bus_cmd_o, (bus_cmd_o == B_WR) ? bus_din_o : 1'b0}, exp_bus.pop_front());
        end
      end
      if (data_rx_valid_o && data_rx_ready_i) begin
        if (exp_rx.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_extra: got 0x%0h with nothing expected", data_rx_o);
        end else begin
          check("rx_byte", data_rx_o, exp_rx.pop_front());
        end
      end
      if (nack_o) nack_cnt++;
      if (eot_o) eot_cnt++;
      if (err_o) err_cnt++;
      if (data_tx_valid_i && data_tx_ready_o) begin tx_cnt++; tx_taken = 1; end
    end
  end

  // Bus controller model (done 3 cycles after each request) and tx source.
  initial begin
    bus_cmd_done_i = 0; bus_dout_i = 0; data_tx_valid_i = 0; data_tx_i = 8'h00;
    forever begin
      sync();
      bus_cmd_done_i = 0;
      if (pend) begin
        if (lat_cnt <= 1) begin
          bus_cmd_done_i = 1; pend = 0;
          if (pend_cmd == B_RD) bus_dout_i = (rd_q.size() > 0) ? rd_q.pop_front() : 1'b0;
        end else begin
          lat_cnt--;
        end
      end
      if (tx_taken) begin
        if (tx_q.size() > 0) tx_q.delete(0);
        tx_taken = 0;
      end
      data_tx_valid_i = (tx_q.size() > 0);
      data_tx_i = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  initial begin
    int n0, t0, e0, n;
    bit stall_bad;
    rstn_i = 0; sw_rst_i = 0; ext_events_i = 0; udma_cmd_i = 0; udma_cmd_valid_i = 0;
    data_rx_ready_i = 0; bus_al_i = 0;
    repeat (3) sync();
    rstn_i = 1;
    @(negedge clk);
    check("rst_clk_div", clk_div_o, 32'h100);
    check("rst_cmd_ready", udma_cmd_ready_o, 1);
    check("rst_rx_data", data_rx_o, 0);
    check("rst_rx_valid", data_rx_valid_o, 0);
    check("rst_tx_ready", data_tx_ready_o, 0);
    check("rst_bus_valid", bus_cmd_valid_o, 0);
    sync();

    // CFG, START, WRB 0xA4 (slave ACK), STOP
    send_cmd(32'hE000_0020);
    @(negedge clk); check("t1_clk_div", clk_div_o, 32'h20); sync();
    n0 = nack_cnt;
    exp_bus.push_back({B_START, 1'b0});
    send_cmd(32'h0000_0000);
    exp_write(8'hA4); rd_q.push_back(1'b0);
    send_cmd(32'h7000_00A4);
    exp_bus.push_back({B_STOP, 1'b0});
    send_cmd(32'h2000_0000);
    wait_idle("t1");
    check("t1_nack", nack_cnt - n0, 0);
    check("t1_bus_left", exp_bus.size(), 0);

    // RPT 3, WR of three tx bytes
    t0 = tx_cnt;
    exp_write(8'h11); exp_write(8'h22); exp_write(8'h33);
    rd_q.push_back(0); rd_q.push_back(0); rd_q.push_back(0);
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
    send_cmd(32'hC000_0003);
    send_cmd(32'h8000_0000);
    wait_idle("t2");
    check("t2_tx_consumed", tx_cnt - t0, 3);
    check("t2_bus_left", exp_bus.size(), 0);

    // RPT 2, RD_ACK with rx back-pressure on the first byte
    exp_read(8'h5A, 1'b0); exp_read(8'hC3, 1'b0);
    send_cmd(32'hC000_0002);
    send_cmd(32'h4000_0000);
    n = 0;
    do begin @(negedge clk); n++; end while (!data_rx_valid_o && n < 500);
    check("t3_rx_valid_seen", data_rx_valid_o, 1);
    stall_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!data_rx_valid_o || bus_cmd_valid_o) stall_bad = 1;
    end
    check("t3_rx_stall", stall_bad, 0);
    sync();
    data_rx_ready_i = 1;
    wait_idle("t3");
    data_rx_ready_i = 0;
    check("t3_rx_left", exp_rx.size(), 0);
    check("t3_bus_left", exp_bus.size(), 0);

    // NACK abort: ack_chk on, RPT 4, slave NACKs byte 2
    send_cmd(32'hE800_0020);
    n0 = nack_cnt; t0 = tx_cnt;
    exp_write(8'h01); exp_write(8'h02);
    rd_q.push_back(0); rd_q.push_back(1);
    tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03); tx_q.push_back(8'h04);
    send_cmd(32'hC000_0004);
    send_cmd(32'h8000_0000);
    wait_idle("t4");
    check("t4_nack_pulses", nack_cnt - n0, 1);
    check("t4_tx_consumed", tx_cnt - t0, 2);
    check("t4_bus_left", exp_bus.size(), 0);
    tx_q.delete();
    sync();
    send_cmd(32'hE000_0020);

    // WAIT arg 2 -> three WAIT slots; EOT; unknown opcode
    repeat (3) exp_bus.push_back({B_WAIT, 1'b0});
    send_cmd(32'hA000_0002);
    wait_idle("t5_wait");
    check("t5_bus_left", exp_bus.size(), 0);
    e0 = eot_cnt;
    send_cmd(32'h9000_0000);
    check("t5_eot", eot_cnt - e0, 1);
    send_cmd(32'h3000_0000);
    @(negedge clk); check("t5_unknown_ready", udma_cmd_ready_o, 1); sync();

    // WAIT_EV select 2, arg 1: needs two ev2 pulses, ev0 ignored
    send_cmd(32'h1200_0001);
    pulse_ev(0); check("t6_after_ev0", udma_cmd_ready_o, 0); sync();
    pulse_ev(2); check("t6_after_ev2a", udma_cmd_ready_o, 0); sync();
    pulse_ev(2); check("t6_after_ev2b", udma_cmd_ready_o, 1); sync();

    // sw_rst_i in the middle of a read
    exp_bus.push_back({B_RD, 1'b0});
    send_cmd(32'h6000_0000);
    sw_rst_i = 1;
    @(negedge clk);
    check("t7_drain_tx_ready", data_tx_ready_o, 1);
    check("t7_drain_rx_valid", data_rx_valid_o, 1);
    check("t7_no_bus_in_rst", bus_cmd_valid_o, 0);
    sync();
    sw_rst_i = 0;
    @(negedge clk);
    check("t7_idle", udma_cmd_ready_o, 1);
    check("t7_clk_div", clk_div_o, 32'h100);
    check("t7_rx_data", data_rx_o, 0);
    repeat (6) sync();
    check("t7_bus_left", exp_bus.size(), 0);
    check("end_rd_left", rd_q.size(), 0);
    check("end_err_pulses", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
